adc_frame_ctrl: RTL and testbench
=================================

Name: adc_frame_ctrl

Overview:
- Sequences capture of one ADC sample stream into the single-clock show-ahead ADC FIFO as a triggered frame: pre-trigger history, trigger search, post-trigger fill.
- Hands the full frame to the HPS read path and re-arms once it has been drained.
- Publishes `adc_ctrl_state[2:0]`; the HPS readout logic keys on this code (READ=5).
- Sits between the ADC sample interface, the ADC FIFO, and the HPS readout logic.

Parameters:
- `FIFO_WORDS`, 256, FIFO depth in words.
- `EXPONENT`, 8, width of `fifo_usedw` (log2 `FIFO_WORDS`).
- `PRETRIG_WORDS`, 64, history depth held before trigger search starts; must be less than `FIFO_WORDS-1`.
- `AUTO_TRIG_CYCLES`, 4096, valid-sample count before forced trigger (optional feature only).

Ports:
- `clk` in 1: system/ADC clock.
- `reset_n` in 1: synchronous reset, active-low.
- `adc_valid` in 1: one-cycle strobe, new sample on `adc_data`.
- `adc_data` in 12: ADC sample, unsigned.
- `trig_en` in 1: 1 = level trigger, 0 = free-run (immediate trigger).
- `trig_level` in 12: rising-edge trigger threshold, unsigned.
- `hps_rdrq` in 1: HPS readout request/enable (level).
- `hps_rd_strobe` in 1: one-cycle pulse, HPS consumed current FIFO head.
- `fifo_usedw` in EXPONENT: FIFO fill level.
- `fifo_wrfull` in 1: FIFO full.
- `fifo_empty` in 1: FIFO empty.
- `fifo_wrreq` out 1: FIFO write enable.
- `fifo_data` out 12: FIFO write data.
- `fifo_rdreq` out 1: FIFO read/pop.
- `fifo_sclr` out 1: FIFO synchronous clear.
- `adc_ctrl_state` out 3: current state code.
- `trig_pos` out EXPONENT: `fifo_usedw` value latched at trigger.
- `frame_count` out 16: completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset (`reset_n`=0 at a `clk` edge) forces the following on the next cycle, from any state including mid-frame:
  - state START;
  - all outputs 0, except `fifo_sclr`=1;
  - `frame_count`=0;
  - `prev_sample` register=0xFFF.
- State codes: START=0, WRITE=1, MAKEROOM=2, WAIT=3, DONE=4, READ=5. Codes 6 and 7 are unreachable; if entered, go to START.
- START:
  - `fifo_sclr`=1 for exactly one cycle, `prev_sample`←0xFFF, then WRITE.
  - No writes in START.
- WRITE (pre-fill):
  - Each `adc_valid` → `fifo_wrreq`=1, `fifo_data`=`adc_data` in the same cycle (combinational, 0 latency).
  - `prev_sample`←`adc_data`.
  - Go to MAKEROOM when `fifo_usedw` ≥ `PRETRIG_WORDS` is observed.
- MAKEROOM (trigger search, rolling history):
  - Each `adc_valid` → `fifo_rdreq`=1 and `fifo_wrreq`=1 in the same cycle, so fill stays constant.
  - Trigger = (`trig_en`=0) OR (`prev_sample` < `trig_level` AND `adc_data` ≥ `trig_level`). Comparison is unsigned 12-bit.
  - `prev_sample`=0xFFF after START guarantees no false trigger on the first sample.
  - On trigger: the sample is still written (with pop), `trig_pos`←`fifo_usedw`, then WAIT.
- WAIT (post-trigger fill):
  - Each `adc_valid` writes without pop.
  - If `fifo_wrfull`=1, `fifo_wrreq` is suppressed and the state goes to DONE; no write while full, ever.
- DONE:
  - `frame_count`+1 on entry (one increment per frame).
  - Samples are ignored.
  - When `hps_rdrq`=1, go to READ.
- READ:
  - `fifo_rdreq`=`hps_rd_strobe` AND NOT `fifo_empty`; pops on empty are dropped.
  - `fifo_wrreq`=0.
  - Go to START when `fifo_empty`=1 AND `hps_rdrq`=0.
  - If empty and `hps_rdrq` is still high, stay in READ.
- `hps_rdrq` falling before the FIFO is empty: stay in READ, frame preserved; the HPS may resume.
- `trig_en`/`trig_level` changes take effect on the next sample; no latching.
- `fifo_rdreq` and `fifo_wrreq` are never both asserted outside MAKEROOM.

Optional Feature:
- Macro: `ADC_FRAME_AUTO_TRIG_EN`.
- Defined:
  - 16-bit counter counts `adc_valid` in MAKEROOM and clears on entry to MAKEROOM.
  - Reaching `AUTO_TRIG_CYCLES` forces a trigger on that sample.
  - Extra output `auto_trig` (1 bit): set on a forced trigger, cleared in START, reset 0.
- Not defined:
  - Counter and `auto_trig` port are absent.
  - MAKEROOM waits indefinitely for a level trigger.

Test Plan:
- Reset then `trig_en`=0, continuous `adc_valid`:
  - START→WRITE in 1 cycle, `fifo_sclr` pulse of width 1;
  - MAKEROOM at `usedw`=64;
  - immediate trigger with `trig_pos`=64;
  - DONE at full with exactly 255 writes total (`FIFO_WORDS-1` per `wrfull`);
  - `frame_count`=1.
- `trig_en`=1, `trig_level`=0x800, ramp 0x000..0xFFF step 0x10:
  - trigger on sample 0x800 (`prev` 0x7F0);
  - no trigger on a flat 0x900 input;
  - a falling 0x900→0x700 sequence does not trigger.
- First sample after START = 0x900 with `trig_level`=0x800: no trigger, confirming the 0xFFF preload.
- DONE, `hps_rdrq`=1, 255 `hps_rd_strobe` pulses:
  - 255 `fifo_rdreq`;
  - strobes after empty produce no `rdreq`;
  - stays in READ until `hps_rdrq`=0, then START, second frame, `frame_count`=2.
- Assert `reset_n`=0 for 1 cycle while in WAIT with `usedw`=150: next state START, `fifo_sclr`=1, `frame_count`=0, `trig_pos`=0.
- `ADC_FRAME_AUTO_TRIG_EN`, `AUTO_TRIG_CYCLES`=100, constant 0x000 input, `trig_level`=0x800: forced trigger on the 100th MAKEROOM sample, `auto_trig`=1, cleared in next START.

Source files
------------

// File: rtl/adc_frame_ctrl.sv
// rtl/adc_frame_ctrl.sv - triggered ADC frame capture into a show-ahead FIFO with HPS readout handoff
// Optional forced trigger after AUTO_TRIG_CYCLES search samples: define ADC_FRAME_AUTO_TRIG_EN.
module adc_frame_ctrl #(
  parameter int FIFO_WORDS    = 256,
  parameter int EXPONENT      = 8,
  parameter int PRETRIG_WORDS = 64
`ifdef ADC_FRAME_AUTO_TRIG_EN
  ,
  parameter int AUTO_TRIG_CYCLES = 4096
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                adc_valid,
  input  logic [11:0]         adc_data,
  input  logic                trig_en,
  input  logic [11:0]         trig_level,
  input  logic                hps_rdrq,
  input  logic                hps_rd_strobe,
  input  logic [EXPONENT-1:0] fifo_usedw,
  input  logic                fifo_wrfull,
  input  logic                fifo_empty,
  output logic                fifo_wrreq,
  output logic [11:0]         fifo_data,
  output logic                fifo_rdreq,
  output logic                fifo_sclr,
  output logic [2:0]          adc_ctrl_state,
  output logic [EXPONENT-1:0] trig_pos,
`ifdef ADC_FRAME_AUTO_TRIG_EN
  output logic                auto_trig,
`endif
  output logic [15:0]         frame_count
);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WRITE    = 3'd1,
    ST_MAKEROOM = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DONE     = 3'd4,
    ST_READ     = 3'd5
  } state_t;

  localparam int LP_PRE = (PRETRIG_WORDS < FIFO_WORDS - 1) ? PRETRIG_WORDS : FIFO_WORDS - 2;
  localparam logic [EXPONENT-1:0] LP_PRE_W  = EXPONENT'(LP_PRE);
  localparam logic [EXPONENT-1:0] LP_PRE_M1 = EXPONENT'(LP_PRE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [11:0]   r_prev_sample;
  logic          w_wr;
  logic          w_rd;
  logic          w_trig;
  logic          w_force;

`ifdef ADC_FRAME_AUTO_TRIG_EN
  logic [15:0]   r_auto_cnt;
  assign w_force = adc_valid && (r_auto_cnt == 16'(AUTO_TRIG_CYCLES - 1));
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    w_trig = 1'b0;
    case (r_state)
      ST_START: w_next = ST_WRITE;
      ST_WRITE: begin
        w_wr = adc_valid && (fifo_usedw < LP_PRE_W);
        // Look ahead on the write that completes the history so no sample is lost at the handover.
        if (fifo_usedw >= LP_PRE_W || (w_wr && fifo_usedw == LP_PRE_M1))
          w_next = ST_MAKEROOM;
      end
      ST_MAKEROOM: begin
        if (adc_valid) begin
          w_wr   = 1'b1;
          w_rd   = !fifo_empty;
          w_trig = !trig_en || (r_prev_sample < trig_level && adc_data >= trig_level) || w_force;
          if (w_trig)
            w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_wrfull)
          w_next = ST_DONE;
        else
          w_wr = adc_valid;
      end
      ST_DONE: begin
        if (hps_rdrq)
          w_next = ST_READ;
      end
      ST_READ: begin
        w_rd = hps_rd_strobe && !fifo_empty;
        if (fifo_empty && !hps_rdrq)
          w_next = ST_START;
      end
      default: w_next = ST_START;
    endcase
  end

  assign fifo_wrreq     = w_wr && !fifo_wrfull;
  assign fifo_rdreq     = w_rd;
  assign fifo_data      = fifo_wrreq ? adc_data : 12'd0;
  assign fifo_sclr      = (r_state == ST_START);
  assign adc_ctrl_state = r_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_START;
      r_prev_sample <= 12'hFFF;
      trig_pos      <= '0;
      frame_count   <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_START)
        r_prev_sample <= 12'hFFF;
      else if (fifo_wrreq && (r_state == ST_WRITE || r_state == ST_MAKEROOM))
        r_prev_sample <= adc_data;
      if (r_state == ST_MAKEROOM && w_trig)
        trig_pos <= fifo_usedw;
      if (r_state == ST_WAIT && w_next == ST_DONE)
        frame_count <= frame_count + 16'd1;
    end
  end

`ifdef ADC_FRAME_AUTO_TRIG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_auto_cnt <= 16'd0;
      auto_trig  <= 1'b0;
    end else begin
      if (r_state != ST_MAKEROOM)
        r_auto_cnt <= 16'd0;
      else if (adc_valid)
        r_auto_cnt <= r_auto_cnt + 16'd1;
      if (w_next == ST_START)
        auto_trig <= 1'b0;
      else if (r_state == ST_MAKEROOM && w_force)
        auto_trig <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// tb/tb_adc_frame_ctrl.sv - randomized frame capture bench with FIFO and trigger reference model
module tb_adc_frame_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        trig_en = 1'b0;
  logic [11:0] trig_level = 12'h800;
  logic        hps_rdrq = 1'b0;
  logic        hps_rd_strobe = 1'b0;
  logic [7:0]  fifo_usedw;
  logic        fifo_wrfull, fifo_empty;
  logic        fifo_wrreq, fifo_rdreq, fifo_sclr;
  logic [11:0] fifo_data;
  logic [2:0]  adc_ctrl_state;
  logic [7:0]  trig_pos;
  logic [15:0] frame_count;
`ifdef ADC_FRAME_AUTO_TRIG_EN
  logic        auto_trig;
`endif

  always #5 clk = ~clk;

`ifdef ADC_FRAME_AUTO_TRIG_EN
  adc_frame_ctrl #(.AUTO_TRIG_CYCLES(100)) dut (
`else
  adc_frame_ctrl dut (
`endif
    .clk(clk), .reset_n(reset_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .trig_en(trig_en), .trig_level(trig_level), .hps_rdrq(hps_rdrq),
    .hps_rd_strobe(hps_rd_strobe), .fifo_usedw(fifo_usedw), .fifo_wrfull(fifo_wrfull),
    .fifo_empty(fifo_empty), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr), .adc_ctrl_state(adc_ctrl_state),
    .trig_pos(trig_pos),
`ifdef ADC_FRAME_AUTO_TRIG_EN
    .auto_trig(auto_trig),
`endif
    .frame_count(frame_count)
  );

  int errors = 0;
  int checks = 0;

  // Show-ahead FIFO that reports full once FIFO_WORDS-1 words are held.
  logic [11:0] fq[$];
  int  fcount = 0;
  bit  wr_full_bad = 0;
  bit  rw_both_bad = 0;
  assign fifo_usedw  = fcount[7:0];
  assign fifo_wrfull = (fcount >= 255);
  assign fifo_empty  = (fcount == 0);

  always @(posedge clk) begin
    if (fifo_wrreq && fifo_rdreq && adc_ctrl_state != 3'd2) rw_both_bad = 1;
    if (fifo_sclr) fq.delete();
    else begin
      if (fifo_rdreq && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wrreq) begin
        if (fq.size() >= 255) wr_full_bad = 1;
        else fq.push_back(fifo_data);
      end
    end
    fcount <= fq.size();
  end

  logic [2:0] last_st = 3'd0;
  int mk_usedw = -1;
  always @(negedge clk) begin
    if (adc_ctrl_state == 3'd2 && last_st != 3'd2) mk_usedw = fcount;
    last_st = adc_ctrl_state;
  end

  logic [11:0] gen[$];
  logic [11:0] S[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Trigger index in the stream of valid samples since START: first 64 fill history.
  function automatic int find_trig(input bit en, input logic [11:0] lvl, input int auto_n);
    for (int i = 64; i < S.size(); i++) begin
      if (!en) return i;
      if (S[i-1] < lvl && S[i] >= lvl) return i;
      if (auto_n > 0 && i - 63 == auto_n) return i;
    end
    return -1;
  endfunction

  task automatic drive_frame(input int vpct, input int stop_cnt, output bit ok);
    int cyc = 0;
    ok = 0;
    S.delete();
    while (cyc < 4000) begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (adc_ctrl_state == 3'd4) begin ok = 1; break; end
      if (stop_cnt > 0 && adc_ctrl_state == 3'd3 && fcount == stop_cnt) begin ok = 1; break; end
      if (gen.size() > 0 && $urandom_range(99) < vpct) begin
        adc_valid = 1'b1;
        adc_data  = gen.pop_front();
        S.push_back(adc_data);
      end
      cyc++;
    end
    adc_valid = 1'b0;
  endtask

  task automatic frame_done(input int t, input int fc);
    check("trig_found", (t >= 64) ? 1 : 0, 1);
    check("done_state", adc_ctrl_state, 3'd4);
    check("makeroom_usedw", mk_usedw, 64);
    check("trig_pos", trig_pos, 64);
    check("full_level", fcount, 255);
    check("frame_count", frame_count, fc);
  endtask

  task automatic read_frame(input int t, input bit pause);
    logic [11:0] got[$];
    int n_rd = 0, extra = 0, cyc = 0, bad = 0, idx;
    bit paused = 0;
    @(negedge clk);
    hps_rdrq = 1'b1;
    while (extra < 5 && cyc < 3000) begin
      @(negedge clk);
      if (pause && !paused && n_rd == 100) begin
        hps_rdrq = 1'b0;
        hps_rd_strobe = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_hold", adc_ctrl_state, 3'd5);
        check("pause_level", fcount, 155);
        hps_rdrq = 1'b1;
        paused = 1;
        @(negedge clk);
      end
      hps_rd_strobe = ($urandom_range(1) == 1);
      #1;
      if (fifo_rdreq) begin
        n_rd++;
        if (fq.size() > 0) got.push_back(fq[0]);
      end
      if (hps_rd_strobe && adc_ctrl_state == 3'd5 && fcount == 0) extra++;
      cyc++;
    end
    hps_rd_strobe = 1'b0;
    check("rd_count", n_rd, 255);
    for (int k = 0; k < 255; k++) begin
      idx = t - 63 + k;
      if (idx < 0 || idx >= S.size() || k >= got.size()) bad++;
      else if (got[k] !== S[idx]) bad++;
    end
    check("frame_data_bad_words", bad, 0);
    check("read_hold_empty", adc_ctrl_state, 3'd5);
    @(negedge clk);
    hps_rdrq = 1'b0;
    @(negedge clk);
    check("rearm_start", adc_ctrl_state, 3'd0);
    check("rearm_sclr", fifo_sclr, 1'b1);
  endtask

  initial begin
    bit ok;
    int t;
    repeat (2) @(negedge clk);
    check("rst_state", adc_ctrl_state, 3'd0);
    check("rst_sclr", fifo_sclr, 1'b1);
    check("rst_wrreq", fifo_wrreq, 1'b0);
    check("rst_rdreq", fifo_rdreq, 1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_trig_pos", trig_pos, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("start_to_write", adc_ctrl_state, 3'd1);
    check("sclr_width", fifo_sclr, 1'b0);

    // Frame 1: free-run, continuous samples.
    trig_en = 1'b0;
    repeat (700) gen.push_back(12'($urandom_range(4095)));
    drive_frame(100, 0, ok);
    check("frame1_timeout", ok, 1'b1);
    t = find_trig(0, 12'h800, 0);
    frame_done(t, 1);
    read_frame(t, 0);

    // Frame 2: directed flat, falling and ramp segments around level 0x800.
    trig_en = 1'b1;
    trig_level = 12'h800;
    gen.delete();
    gen.push_back(12'h900);
    repeat (62) gen.push_back(12'($urandom_range(4095)));
    repeat (21) gen.push_back(12'h900);
    gen.push_back(12'h900); gen.push_back(12'h850); gen.push_back(12'h800);
    gen.push_back(12'h7A0); gen.push_back(12'h700);
    for (int v = 0; v < 4096; v += 16) gen.push_back(12'(v));
    repeat (300) gen.push_back(12'($urandom_range(4095)));
    drive_frame(60, 0, ok);
    check("frame2_timeout", ok, 1'b1);
    t = find_trig(1, 12'h800, 0);
    check("frame2_trig_index", t, 64 + 20 + 5 + 128);
    frame_done(t, 2);
    read_frame(t, 1);

    // Frame 3: random level and random samples, ramp appended to guarantee a crossing.
    trig_level = 12'($urandom_range(12'hFF0, 1));
    gen.delete();
    repeat (364) gen.push_back(12'($urandom_range(4095)));
    for (int v = 0; v < 4096; v += 16) gen.push_back(12'(v));
    repeat (300) gen.push_back(12'($urandom_range(4095)));
    drive_frame(80, 0, ok);
    check("frame3_timeout", ok, 1'b1);
    t = find_trig(1, trig_level, 0);
    frame_done(t, 3);
    read_frame(t, 0);

    // Reset mid-WAIT at fill 150.
    trig_en = 1'b0;
    gen.delete();
    repeat (400) gen.push_back(12'($urandom_range(4095)));
    drive_frame(90, 150, ok);
    check("wait150_reached", ok, 1'b1);
    check("wait150_state", adc_ctrl_state, 3'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_state", adc_ctrl_state, 3'd0);
    check("midrst_sclr", fifo_sclr, 1'b1);
    check("midrst_frame_count", frame_count, 16'd0);
    check("midrst_trig_pos", trig_pos, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_write", adc_ctrl_state, 3'd1);

`ifdef ADC_FRAME_AUTO_TRIG_EN
    trig_en = 1'b1;
    trig_level = 12'h800;
    gen.delete();
    repeat (600) gen.push_back(12'h000);
    drive_frame(100, 0, ok);
    check("auto_timeout", ok, 1'b1);
    t = find_trig(1, 12'h800, 100);
    check("auto_index", t, 163);
    check("auto_trig_set", auto_trig, 1'b1);
    frame_done(t, 1);
    read_frame(t, 0);
    check("auto_trig_clear", auto_trig, 1'b0);
`endif

    check("no_write_when_full", wr_full_bad, 1'b0);
    check("no_rw_outside_makeroom", rw_both_bad, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
